// File: rtl/bist_controller.sv
// bist_controller: built-in self-test sequencer for the wrapped CUT.
// An LFSR (x^5+x^3+1) drives the CUT's five stimulus inputs, a MISR
// (x^9+x^4+1) compacts its nine response bits, and the final signature
// is compared with GOLDEN_SIG. Outside a run, func_in passes through.
// Optional feature: define BIST_SIGNATURE_OUT_EN to add the sig_out port,
// which exposes the live MISR value.
// Handshake: bist_start is level-sampled in IDLE and launches one run;
// bist_end stays high in DONE until bist_start drops, so a new run always
// needs bist_start low for at least one cycle after DONE.
module bist_controller #(
   parameter int unsigned N_PATTERNS = 31,
   parameter logic [4:0]  LFSR_SEED  = 5'b00001,
   parameter logic [8:0]  GOLDEN_SIG = 9'h000
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       bist_start,
   input  logic [4:0] func_in,
   output logic [4:0] cut_in,
   input  logic [8:0] cut_resp,
   output logic       bist_active,
   output logic       bist_end,
   output logic       pass_nfail
`ifdef BIST_SIGNATURE_OUT_EN
   ,
   output logic [8:0] sig_out
`endif
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RUN     = 2'd1,
      COMPARE = 2'd2,
      DONE    = 2'd3
   } state_t;

   // An all-zero seed would lock the LFSR, so it is replaced by 00001.
   localparam logic [4:0] SEED = (LFSR_SEED == 5'd0) ? 5'd1 : LFSR_SEED;
   // Counter value seen at the edge that applies the final capture.
   localparam logic [4:0] LAST = 5'(N_PATTERNS - 1);

   // state is kept as a named register so checkers can bind to it directly
   state_t     state;
   state_t     state_next;
   logic [4:0] lfsr;
   logic [4:0] lfsr_next;
   logic [8:0] misr;
   logic [8:0] misr_next;
   logic [4:0] count;
   logic       last_pattern;

   // Pattern generator and response compactor next-state functions
   always_comb begin
      lfsr_next    = {lfsr[3:0], lfsr[4] ^ lfsr[2]};
      misr_next    = {misr[7:0], misr[8]} ^ {4'b0000, misr[8], 4'b0000} ^ cut_resp;
      last_pattern = (count == LAST);
   end

   // State register
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (bist_start) state_next = RUN;
         RUN:     if (last_pattern) state_next = COMPARE;
         COMPARE: state_next = DONE;
         DONE:    if (!bist_start) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Datapath: LFSR, MISR, pattern counter and registered result
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         lfsr       <= SEED;
         misr       <= 9'd0;
         count      <= 5'd0;
         pass_nfail <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bist_start) begin
                  lfsr       <= SEED;
                  misr       <= 9'd0;
                  count      <= 5'd0;
                  pass_nfail <= 1'b0;
               end
            end
            RUN: begin
               lfsr  <= lfsr_next;
               misr  <= misr_next;
               count <= count + 5'd1;
            end
            COMPARE: pass_nfail <= (misr == GOLDEN_SIG);
            default: ;
         endcase
      end
   end

   // Stimulus mux and status outputs decoded from the state register
   always_comb begin
      cut_in      = (state == RUN) ? lfsr : func_in;
      bist_active = (state == RUN);
      bist_end    = (state == DONE);
   end

`ifdef BIST_SIGNATURE_OUT_EN
   assign sig_out = misr;
`endif

endmodule

// File: tb/tb_bist_controller.sv
// tb_bist_controller: self-test bench for bist_controller.
// Three instances: dut_a (31 patterns, seed 00001), dut_b (1 pattern),
// dut_c (5 patterns, seed 0 which must become 00001). Expected patterns
// and signatures come from a reference model of the polynomials.
module tb_bist_controller;

   logic       clock = 1'b0;
   logic       reset;
   logic [4:0] func_in;
   logic       start_a, start_b, start_c;
   logic [8:0] resp_a, resp_b, resp_c;
   logic [4:0] cut_in_a, cut_in_b, cut_in_c;
   logic       active_a, active_b, active_c;
   logic       end_a, end_b, end_c;
   logic       pass_a, pass_b, pass_c;
`ifdef BIST_SIGNATURE_OUT_EN
   logic [8:0] sig_a, sig_b, sig_c;
`endif

   int checks = 0;
   int fails  = 0;
   logic [4:0] pat [0:30];

   // Clock
   always #5 clock = ~clock;

   bist_controller #(.N_PATTERNS(31), .LFSR_SEED(5'b00001), .GOLDEN_SIG(9'h000)) dut_a (
      .clock(clock), .reset(reset), .bist_start(start_a), .func_in(func_in),
      .cut_in(cut_in_a), .cut_resp(resp_a), .bist_active(active_a),
      .bist_end(end_a), .pass_nfail(pass_a)
`ifdef BIST_SIGNATURE_OUT_EN
      , .sig_out(sig_a)
`endif
   );

   bist_controller #(.N_PATTERNS(1), .LFSR_SEED(5'b00001), .GOLDEN_SIG(9'h000)) dut_b (
      .clock(clock), .reset(reset), .bist_start(start_b), .func_in(func_in),
      .cut_in(cut_in_b), .cut_resp(resp_b), .bist_active(active_b),
      .bist_end(end_b), .pass_nfail(pass_b)
`ifdef BIST_SIGNATURE_OUT_EN
      , .sig_out(sig_b)
`endif
   );

   bist_controller #(.N_PATTERNS(5), .LFSR_SEED(5'b00000), .GOLDEN_SIG(9'h000)) dut_c (
      .clock(clock), .reset(reset), .bist_start(start_c), .func_in(func_in),
      .cut_in(cut_in_c), .cut_resp(resp_c), .bist_active(active_c),
      .bist_end(end_c), .pass_nfail(pass_c)
`ifdef BIST_SIGNATURE_OUT_EN
      , .sig_out(sig_c)
`endif
   );

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] exp);
      checks++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Reference MISR step as polynomial arithmetic: multiply by x modulo
   // x^9+x^4+1, then add the response vector.
   function automatic logic [8:0] misr_model(input logic [8:0] m, input logic [8:0] r);
      int unsigned v;
      v = int'(m) * 2;
      if (v >= 512) v = (v - 512) ^ 32'h011;
      return 9'(v) ^ r;
   endfunction

   // One complete run on dut_a; rnd selects random responses, hold keeps
   // bist_start high through the run.
   task automatic run_a(input bit rnd, input bit hold, output logic [8:0] sig);
      logic [8:0] m;
      logic [8:0] r;
      logic [4:0] first5 [0:4];
      first5 = '{5'b00001, 5'b00010, 5'b00100, 5'b01001, 5'b10010};
      m = 9'd0;
      start_a = 1'b1;
      tick();
      if (!hold) start_a = 1'b0;
      chk("start_clears_pass", pass_a, 9'd0);
      for (int k = 0; k < 31; k++) begin
         func_in = 5'($urandom_range(0, 31));
         #1;
         chk("run_pattern", cut_in_a, pat[k]);
         if (k < 5) chk("first_patterns", cut_in_a, first5[k]);
         chk("run_active", active_a, 9'd1);
         chk("run_end", end_a, 9'd0);
         r = rnd ? 9'($urandom_range(0, 511)) : 9'd0;
         resp_a = r;
         m = misr_model(m, r);
         tick();
      end
      func_in = 5'($urandom_range(0, 31));
      #1;
      chk("compare_active", active_a, 9'd0);
      chk("compare_end", end_a, 9'd0);
      chk("compare_cut_in", cut_in_a, 9'(func_in));
      tick();
      chk("done_end", end_a, 9'd1);
      chk("done_pass", pass_a, 9'(m == 9'h000));
      chk("done_active", active_a, 9'd0);
`ifdef BIST_SIGNATURE_OUT_EN
      chk("done_sig", sig_a, m);
`endif
      sig = m;
   endtask

   initial begin
      logic [8:0] sig1, sig2, m;
      reset = 1'b0;
      start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
      resp_a = 9'd0; resp_b = 9'd0; resp_c = 9'd0;
      func_in = 5'h13;

      pat[0] = 5'b00001;
      for (int k = 1; k < 31; k++) begin
         pat[k] = 5'((int'(pat[k-1]) * 2) % 32) | 5'(pat[k-1][4] ^ pat[k-1][2]);
      end

      // Reset state
      repeat (3) tick();
      chk("rst_active_a", active_a, 9'd0);
      chk("rst_end_a", end_a, 9'd0);
      chk("rst_pass_a", pass_a, 9'd0);
      chk("rst_cut_in_a", cut_in_a, 9'(func_in));
      chk("rst_end_b", end_b, 9'd0);
      chk("rst_end_c", end_c, 9'd0);
`ifdef BIST_SIGNATURE_OUT_EN
      chk("rst_sig_a", sig_a, 9'd0);
`endif
      reset = 1'b1;
      tick();

      // Normal mode pass-through
      func_in = 5'b10110;
      #1;
      chk("norm_cut_in_a", cut_in_a, 9'h016);
      chk("norm_cut_in_b", cut_in_b, 9'h016);
      chk("norm_cut_in_c", cut_in_c, 9'h016);
      tick();
      func_in = 5'b01011;
      #1;
      chk("norm_cut_in_a2", cut_in_a, 9'h00b);
      tick();
      chk("norm_active", active_a, 9'd0);
      chk("norm_end", end_a, 9'd0);
      chk("norm_pass", pass_a, 9'd0);

      // Pass run with start held, then held in DONE
      run_a(1'b0, 1'b1, sig1);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("hold_end", end_a, 9'd1);
         chk("hold_pass", pass_a, 9'd1);
         chk("hold_active", active_a, 9'd0);
      end

      // Re-run after dropping start for one cycle
      start_a = 1'b0;
      tick();
      chk("idle_after_done", end_a, 9'd0);
      run_a(1'b0, 1'b0, sig2);
      chk("rerun_same_sig", sig2, sig1);
      tick();
      chk("back_to_idle", end_a, 9'd0);

      // Random-response runs
      run_a(1'b1, 1'b0, sig1);
      tick();
      run_a(1'b1, 1'b0, sig1);
      tick();

      // Mid-run reset at RUN cycle 10
      start_a = 1'b1;
      tick();
      start_a = 1'b0;
      repeat (9) tick();
      chk("pre_reset_active", active_a, 9'd1);
      reset = 1'b0;
      func_in = 5'b11001;
      #1;
      chk("mid_reset_active", active_a, 9'd0);
      chk("mid_reset_cut_in", cut_in_a, 9'h019);
      chk("mid_reset_end", end_a, 9'd0);
      tick();
      reset = 1'b1;
      for (int i = 0; i < 40; i++) begin
         tick();
         chk("no_partial_end", end_a, 9'd0);
      end
      run_a(1'b1, 1'b0, sig1);
      tick();

      // Minimum run on dut_b with a failing response
      start_b = 1'b1;
      tick();
      start_b = 1'b0;
      chk("min_cut_in", cut_in_b, 9'h001);
      chk("min_active", active_b, 9'd1);
      resp_b = 9'h001;
      m = misr_model(9'd0, 9'h001);
      tick();
      chk("min_compare_active", active_b, 9'd0);
      chk("min_compare_end", end_b, 9'd0);
      tick();
      chk("min_end", end_b, 9'd1);
      chk("min_pass", pass_b, 9'(m == 9'h000));
`ifdef BIST_SIGNATURE_OUT_EN
      chk("min_sig", sig_b, m);
`endif
      tick();
      chk("min_idle", end_b, 9'd0);

      // Zero seed on dut_c is replaced by 00001
      start_c = 1'b1;
      tick();
      start_c = 1'b0;
      for (int k = 0; k < 5; k++) begin
         chk("seed0_pattern", cut_in_c, pat[k]);
         chk("seed0_active", active_c, 9'd1);
         tick();
      end
      chk("seed0_compare_end", end_c, 9'd0);
      tick();
      chk("seed0_end", end_c, 9'd1);
      chk("seed0_pass", pass_c, 9'd1);
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule

// File: doc/bist_controller.md
# bist_controller

Built-in self-test sequencer for the CUT in the top-level wrapper. On `bist_start`, the block takes over the CUT's five stimulus inputs (`s`, `dv`, `l_in`, `test_in[1:0]`) and drives them from a 5-bit LFSR pattern generator. It compacts the CUT's nine response bits (`fz_L`, `lclk`, `read_a[4:0]`, `test_out[1:0]`) into a 9-bit MISR, then compares the signature with a golden value and reports `bist_end` and `pass_nfail`. When it is not testing, it passes the functional stimulus straight through to the CUT.

## Interface
Parameters:
- `N_PATTERNS`, default 31: number of LFSR patterns applied per run; legal range 1..31.
- `LFSR_SEED`, default 5'b00001: initial LFSR state; the value 0 is replaced by 5'b00001.
- `GOLDEN_SIG`, default 9'h000: expected MISR signature at the end of the run.

Ports:
- `clock` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `bist_start` input 1: request a self-test run; level-sampled in IDLE.
- `func_in` input 5: functional stimulus `{s, dv, l_in, test_in[1:0]}`.
- `cut_in` output 5: stimulus to the CUT, same bit order as `func_in`.
- `cut_resp` input 9: CUT response `{fz_L, lclk, read_a[4:0], test_out[1:0]}`.
- `bist_active` output 1: high while the block owns `cut_in` (RUN state).
- `bist_end` output 1: high in DONE.
- `pass_nfail` output 1: comparison result; valid only while `bist_end` is 1.

## Operation
- State machine with four states: IDLE, RUN, COMPARE, DONE.
- IDLE:
  - `cut_in` = `func_in`, combinational pass-through.
  - When `bist_start` is 1 at a clock edge: load the LFSR with the seed, clear the MISR, clear the pattern counter, clear `pass_nfail`, go to RUN.
- RUN:
  - `cut_in` = LFSR state, `bist_active` = 1.
  - Each edge: advance the LFSR, increment the counter, clock the MISR with `cut_resp`.
  - Leave for COMPARE on the edge where the counter reaches `N_PATTERNS`.
- COMPARE:
  - `cut_in` = `func_in`.
  - One cycle: register `pass_nfail` = (MISR == `GOLDEN_SIG`), go to DONE.
- DONE:
  - `bist_end` = 1; `pass_nfail` held.
  - Return to IDLE when `bist_start` is 0.
- LFSR: polynomial x^5+x^3+1, Fibonacci form; next = {lfsr[3:0], lfsr[4]^lfsr[2]}.
  - From seed 00001 the sequence is 00001, 00010, 00100, 01001, 10010, ...
  - Period 31.
- MISR: polynomial x^9+x^4+1; r = `cut_resp`.
  - next[0] = m[8]^r[0].
  - next[4] = m[3]^m[8]^r[4].
  - next[i] = m[i-1]^r[i] for every other i.
- Pattern counter: 5 bits, with no wrap beyond `N_PATTERNS`.

## Timing
- Reset values: state IDLE, LFSR = seed, MISR = 0, counter = 0, `bist_active` = 0, `bist_end` = 0, `pass_nfail` = 0. `cut_in` follows `func_in` while in reset.
- Edge E0 samples `bist_start` = 1; pattern k is on `cut_in` during cycle k+1 (after edge Ek).
- MISR capture edges:
  - The MISR captures at edges E1..E_N, i.e. exactly N responses.
  - The response to pattern k is the one captured at E(k+1).
- COMPARE occupies the cycle after E_N. `bist_end` and `pass_nfail` are registered high after edge E(N+1).
- Start-to-`bist_end` latency is N+1 cycles after the sampling edge.
- `bist_start` deasserted during RUN or COMPARE: ignored; the run completes.
- `bist_start` held high in DONE: stay in DONE; no automatic restart.
- A new run needs `bist_start` low for at least one cycle after DONE.
- `reset` asserted mid-run: immediate return to IDLE with reset values. No partial result is reported.
- `N_PATTERNS` = 1: a single RUN cycle, a single MISR capture, `bist_end` 2 cycles after the sampling edge.

## Configuration
- Macro `BIST_SIGNATURE_OUT_EN`.
- Defined: adds output port `sig_out` (9 bits), which is the live MISR value, reset 0 and updated identically to the internal MISR.
- Undefined: the port does not exist; behaviour is otherwise identical.

## Test plan
- Normal mode:
  - Stimulus: `bist_start` = 0; drive `func_in` = 5'b10110, then 5'b01011.
  - Required: `cut_in` equals `func_in` in the same cycle; `bist_active`, `bist_end` and `pass_nfail` stay 0.
- Pattern order:
  - Stimulus: `N_PATTERNS` = 31, seed 00001, pulse `bist_start`.
  - Required: `cut_in` reads 00001, 00010, 00100, 01001, 10010 in cycles 1..5; `bist_active` is high for exactly 31 cycles.
- Pass:
  - Stimulus: `cut_resp` tied to 0, `GOLDEN_SIG` = 0.
  - Required: `bist_end` = 1 and `pass_nfail` = 1 exactly 32 cycles after the sampling edge; both held while `bist_start` stays high.
- Fail and minimum run:
  - Stimulus: `N_PATTERNS` = 1, `cut_resp` = 9'h001, `GOLDEN_SIG` = 0.
  - Required: MISR = 9'h001 (visible on `sig_out` with the macro defined), `pass_nfail` = 0, `bist_end` = 1 two cycles after start.
- Mid-run reset:
  - Stimulus: assert `reset` low at RUN cycle 10.
  - Required: `bist_active` = 0 at once, `cut_in` = `func_in`, `bist_end` never asserts; a fresh start then completes normally.
- Re-run:
  - Stimulus: after DONE, drop `bist_start` for 1 cycle, then raise it again.
  - Required: `pass_nfail` clears, the LFSR reloads to the seed, and the second run gives the same signature and result.
